// File: rtl/tag_anc_pkg.sv
// Definitions shared by the anchor TX sequencer and the tag RX controller.
// Both ends of the GPIO sync/scan handshake use these masks and state codes.
package tag_anc_pkg;

    localparam logic [11:0] SYNC_MASK = 12'h004;
    localparam logic [11:0] SCAN_MASK = 12'h040;
    localparam logic [11:0] ACK_MASK  = 12'h001;
    localparam logic [11:0] RXV_MASK  = 12'h010;
    localparam logic [11:0] GPIO_DDR  = SYNC_MASK | SCAN_MASK;

    localparam int SYNC_AMP_DEFAULT = 32000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRIG     = 3'd1,
        ST_LOC_SYNC = 3'd2,
        ST_HOP_SYNC = 3'd3,
        ST_HOP_TX   = 3'd4
    } tx_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpio_io_sync.sv
// Front-panel GPIO boundary: 2-FF synchronizer on the inputs, registered
// outputs masked to the driven pins, and the constant direction word.
module gpio_io_sync
    import tag_anc_pkg::*;
#(
    parameter int GPIO_REG_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_out_next,
    output logic [GPIO_REG_WIDTH-1:0] gpio_in_sync,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr
);

    localparam logic [GPIO_REG_WIDTH-1:0] DDR = GPIO_REG_WIDTH'(GPIO_DDR);

    logic [GPIO_REG_WIDTH-1:0] gpio_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_meta    <= '0;
            gpio_in_sync <= '0;
            fp_gpio_out  <= '0;
        end else begin
            gpio_meta    <= fp_gpio_in;
            gpio_in_sync <= gpio_meta;
            fp_gpio_out  <= gpio_out_next & DDR;
        end
    end

    assign fp_gpio_ddr = DDR;

endmodule

// File: rtl/tag_tx_ctrl_anc.sv
// Anchor-side transmit sequencer: per hop it triggers the tag over GPIO, waits
// for its acknowledge, then emits a sync burst, a hop-sync tone and a data window.
module tag_tx_ctrl_anc
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int SYNC_N         = 8192,
    parameter int NUM_HOPS       = 64,
    parameter int TRIG_HOLD      = 64,
    parameter int ACK_TIMEOUT    = 4096,
    parameter int SYNC_AMP       = SYNC_AMP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      scan_mode,
    input  logic [DATA_WIDTH-1:0]     itx_in,
    input  logic [DATA_WIDTH-1:0]     qtx_in,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    output logic                      tx_valid,
    output logic [DATA_WIDTH-1:0]     itx_out,
    output logic [DATA_WIDTH-1:0]     qtx_out,
    output logic [2:0]                tx_state,
    output logic [7:0]                hop_idx,
    output logic                      busy,
    output logic                      err_timeout
);

    // The counter also times the acknowledge window, so it must hold both ranges.
    localparam int CNT_W = $clog2(max_int(3 * SYNC_N + 1, ACK_TIMEOUT));

    localparam logic [CNT_W-1:0] CNT_HOLD      = CNT_W'(TRIG_HOLD);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LOC_LOAD  = CNT_W'(SYNC_N - 1);
    localparam logic [CNT_W-1:0] CNT_LOC_HALF  = CNT_W'(SYNC_N / 2);
    localparam logic [CNT_W-1:0] CNT_HS_SCAN   = CNT_W'(SYNC_N - 1);
    localparam logic [CNT_W-1:0] CNT_HS_NORMAL = CNT_W'(3 * SYNC_N - 1);
    localparam logic [CNT_W-1:0] CNT_TX_LOAD   = CNT_W'(2 * SYNC_N);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [7:0]       LAST_HOP      = 8'(NUM_HOPS - 1);

    localparam logic [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(SYNC_AMP);
    localparam logic [DATA_WIDTH-1:0] AMP_NEG = DATA_WIDTH'(-SYNC_AMP);

    localparam logic [GPIO_REG_WIDTH-1:0] SYNC_BIT = GPIO_REG_WIDTH'(SYNC_MASK);
    localparam logic [GPIO_REG_WIDTH-1:0] SCAN_BIT = GPIO_REG_WIDTH'(SCAN_MASK);
    localparam logic [GPIO_REG_WIDTH-1:0] ACK_BIT  = GPIO_REG_WIDTH'(ACK_MASK);

    tx_state_e                 state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [7:0]                hop_next;
    logic                      scan_r, scan_next;
    logic                      err_next;
    logic                      valid_next;
    logic                      sync_next;
    logic [DATA_WIDTH-1:0]     i_next, q_next;
    logic [GPIO_REG_WIDTH-1:0] gpio_out_next;
    logic [GPIO_REG_WIDTH-1:0] gpio_in_sync;
    logic                      ack_sync;
    logic                      unused_gpio_in;

    gpio_io_sync #(
        .GPIO_REG_WIDTH(GPIO_REG_WIDTH)
    ) u_gpio (
        .clk          (clk),
        .reset        (reset),
        .fp_gpio_in   (fp_gpio_in),
        .gpio_out_next(gpio_out_next),
        .gpio_in_sync (gpio_in_sync),
        .fp_gpio_out  (fp_gpio_out),
        .fp_gpio_ddr  (fp_gpio_ddr)
    );

    // RXV and the other synchronized inputs are reserved for future use.
    assign ack_sync       = |(gpio_in_sync & ACK_BIT);
    assign unused_gpio_in = ^(gpio_in_sync & ~ACK_BIT);

    assign tx_state = state;
    assign busy     = (state != ST_IDLE);

    // NOTE: every variable below gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hop_next   = hop_idx;
        scan_next  = scan_r;
        err_next   = err_timeout;
        valid_next = 1'b0;
        sync_next  = 1'b0;
        i_next     = '0;
        q_next     = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    scan_next  = scan_mode;
                    hop_next   = '0;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                sync_next = (cnt < CNT_HOLD);
                if (ack_sync && (cnt >= CNT_HOLD)) begin
                    cnt_next   = CNT_LOC_LOAD;
                    state_next = ST_LOC_SYNC;
                end else if (cnt == CNT_TIMEOUT) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_LOC_SYNC: begin
                valid_next = 1'b1;
                i_next     = (cnt >= CNT_LOC_HALF) ? AMP_POS : AMP_NEG;
                if (cnt == '0) begin
                    cnt_next   = scan_r ? CNT_HS_SCAN : CNT_HS_NORMAL;
                    state_next = ST_HOP_SYNC;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_HOP_SYNC: begin
                valid_next = 1'b1;
                i_next     = AMP_POS;
                if (cnt == '0) begin
                    cnt_next   = CNT_TX_LOAD;
                    state_next = ST_HOP_TX;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_HOP_TX: begin
                valid_next = 1'b1;
                i_next     = itx_in;
                q_next     = qtx_in;
                if (cnt == '0) begin
                    state_next = (hop_idx == LAST_HOP) ? ST_IDLE : ST_TRIG;
                    if (hop_idx != LAST_HOP) hop_next = hop_idx + 8'd1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including the output of the current cycle.
        if (abort) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            hop_next   = hop_idx;
            err_next   = err_timeout;
            scan_next  = scan_r;
            valid_next = 1'b0;
            sync_next  = 1'b0;
            i_next     = '0;
            q_next     = '0;
        end

        gpio_out_next = (sync_next ? SYNC_BIT : '0)
                      | ((busy && scan_r && !abort) ? SCAN_BIT : '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hop_idx     <= '0;
            scan_r      <= 1'b0;
            err_timeout <= 1'b0;
            tx_valid    <= 1'b0;
            itx_out     <= '0;
            qtx_out     <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            hop_idx     <= hop_next;
            scan_r      <= scan_next;
            err_timeout <= err_next;
            tx_valid    <= valid_next;
            itx_out     <= i_next;
            qtx_out     <= q_next;
        end
    end

endmodule

// File: doc/tag_tx_ctrl_anc.md
Name: tag_tx_ctrl_anc

Overview:
- Anchor-side transmit sequencer. It is the initiating end of the GPIO sync/scan handshake whose responder is the tag RX controller.
- Each hop: raises SYNC_OUT to trigger the tag, waits for the tag's sync-ready acknowledge, then emits a localisation sync burst, a hop-sync interval and a data window.
- Repeats for NUM_HOPS hops per start.
- Sits between the TX sample source and the radio TX path; fp_gpio connects to the front-panel header.

Parameters:
- DATA_WIDTH, 16, IQ sample width (signed two's complement).
- GPIO_REG_WIDTH, 12, front-panel GPIO width.
- SYNC_N, 8192, base sync interval in samples; must be even and >= 4.
- NUM_HOPS, 64, hops per run, 1..256.
- TRIG_HOLD, 64, cycles SYNC_OUT is held high per hop.
- ACK_TIMEOUT, 4096, max cycles from TRIG entry to acknowledge; must be > TRIG_HOLD.
- SYNC_AMP, 32000, sync burst amplitude.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  level; forces return to IDLE.
- scan_mode  in  1  sampled at start; drives SCAN_OUT and selects the hop-sync length.
- itx_in  in  DATA_WIDTH  TX I sample.
- qtx_in  in  DATA_WIDTH  TX Q sample.
- fp_gpio_in  in  GPIO_REG_WIDTH  raw GPIO inputs.
- fp_gpio_out  out  GPIO_REG_WIDTH  GPIO outputs.
- fp_gpio_ddr  out  GPIO_REG_WIDTH  direction; constant GPIO_DDR.
- tx_valid  out  1  itx_out/qtx_out carry a burst sample.
- itx_out  out  DATA_WIDTH  I output.
- qtx_out  out  DATA_WIDTH  Q output.
- tx_state  out  3  current state encoding.
- hop_idx  out  8  current hop number.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky acknowledge-timeout flag.

Behaviour:
- GPIO masks:
  - SYNC_OUT 12'h004, SCAN_OUT 12'h040 (outputs).
  - ACK_IN 12'h001, RXV_IN 12'h010 (inputs).
  - GPIO_DDR = 12'h044.
- fp_gpio_out is registered; bits outside GPIO_DDR are 0.
- fp_gpio_in passes through a 2-FF synchronizer, so acknowledge latency is 2 cycles. RXV_IN is synchronized but unused; it is reserved.
- Reset values: state IDLE, all outputs 0, hop_idx 0, err_timeout 0, counters 0.
- States (tx_state encoding):
  - IDLE=0
  - TRIG=1
  - LOC_SYNC=2
  - HOP_SYNC=3
  - HOP_TX=4
- IDLE:
  - On start: latch scan_mode into scan_r, clear hop_idx and err_timeout, go to TRIG with cnt=0.
  - start is ignored in every other state.
- TRIG:
  - SYNC_OUT=1 while cnt<TRIG_HOLD, else 0. cnt increments every cycle.
  - Synchronized ACK_IN=1 with cnt>=TRIG_HOLD: go to LOC_SYNC with cnt=SYNC_N-1. ACK_IN before TRIG_HOLD is ignored.
  - cnt==ACK_TIMEOUT-1 without acknowledge: set err_timeout, go to IDLE.
- LOC_SYNC:
  - Emit for SYNC_N cycles: cnt>=SYNC_N/2 gives I=+SYNC_AMP, otherwise I=-SYNC_AMP; Q=0.
  - cnt decrements; at cnt==0 go to HOP_SYNC with cnt = scan_r ? SYNC_N-1 : 3*SYNC_N-1.
- HOP_SYNC:
  - I=+SYNC_AMP, Q=0; cnt decrements.
  - At 0, go to HOP_TX with cnt=2*SYNC_N, giving 2*SYNC_N+1 cycles.
- HOP_TX:
  - Pass itx_in/qtx_in through; cnt decrements.
  - At 0: if hop_idx==NUM_HOPS-1, go to IDLE (hop_idx holds its value); else increment hop_idx and go to TRIG with cnt=0.
- SCAN_OUT = scan_r whenever busy, else 0.
- IQ and tx_valid are registered with 1-cycle latency from the state/cnt that produced them.
  - tx_valid=1 for samples produced in LOC_SYNC, HOP_SYNC or HOP_TX.
  - Otherwise outputs are 0.
- Counter width: $clog2(3*SYNC_N+1). No wrap is permitted.
- abort has priority over all transitions. Next cycle: IDLE, SYNC_OUT=0, IQ=0, tx_valid=0, hop_idx unchanged, err_timeout unchanged.
- reset mid-run returns every register to its reset value on the next edge.
- Undefined state encoding recovers to IDLE.

Decomposition:
- Shared package tag_anc_pkg holds:
  - GPIO masks SYNC_MASK, SCAN_MASK, ACK_MASK, RXV_MASK.
  - State encodings.
  - SYNC_AMP default.
  - These are shared with the tag RX controller so both ends agree.
- One natural sub-module, gpio_io_sync: 2-FF input synchronizer plus registered output/ddr. The sequencer FSM stays in tag_tx_ctrl_anc.

Test Plan:
- Nominal, with SYNC_N=16, NUM_HOPS=2, TRIG_HOLD=4, scan_mode=0:
  - start, and ACK_IN is raised 10 cycles later.
  - SYNC_OUT is high exactly 4 cycles.
  - LOC_SYNC gives 8 samples of +32000 then 8 of -32000.
  - HOP_SYNC lasts 48 cycles; HOP_TX passes 33 input samples.
  - hop_idx goes to 1, then the run returns to IDLE.
- scan_mode=1: HOP_SYNC lasts 16 cycles; SCAN_OUT (bit 6) is high for the whole run; fp_gpio_ddr==12'h044.
- Timeout, with ACK_TIMEOUT=32: ACK_IN is never raised, so after 32 cycles in TRIG the block is in IDLE, err_timeout=1, busy=0, and no tx_valid was ever asserted.
- Early acknowledge: ACK_IN is high from start. LOC_SYNC is entered only after TRIG_HOLD, i.e. 4 cycles into TRIG at the earliest.
- Abort asserted during HOP_TX of hop 0: the next cycle is IDLE, tx_valid=0, IQ=0, hop_idx=0. A subsequent start performs a full 2-hop run.
- Reset asserted mid-LOC_SYNC: all outputs are 0 and state=0 on the next edge. start pulses during an active run have no effect on hop count or timing.
